// File: rtl/change_pkg.sv
// Shared coin codes, controller states and payment limit for the coin vending controller.
package change_pkg;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        CIRCLE   = 3'd1,
        TRIANGLE = 3'd3,
        PENTAGON = 3'd5
    } coin_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        EVAL     = 3'd2,
        DISPENSE = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int MAX_PAID = 15;

    function automatic logic coin_valid(input logic [2:0] code);
        return (code == CIRCLE) || (code == TRIANGLE) || (code == PENTAGON);
    endfunction

    function automatic logic [3:0] coin_value(input logic [2:0] code);
        return coin_valid(code) ? {1'b0, code} : 4'd0;
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Change inventory: three 2-bit saturating counters fed by restock, dispense and sale credit.
module coin_inventory
    import change_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_restock,
    input  logic [2:0] i_restock_coin,
    input  logic       i_dispense,
    input  logic [2:0] i_dispense_coin,
    input  logic [2:0] i_credit_c,
    input  logic [2:0] i_credit_t,
    input  logic [2:0] i_credit_p,
    output logic [1:0] o_circles,
    output logic [1:0] o_triangles,
    output logic [1:0] o_pentagons
);

    logic [1:0] r_circles, r_triangles, r_pentagons;
    logic       w_inc_c, w_inc_t, w_inc_p;
    logic       w_dec_c, w_dec_t, w_dec_p;

    // Simultaneous restock and dispense of one type cancel; credit lands after both.
    function automatic logic [1:0] next_count(input logic [1:0] cnt, input logic inc,
                                              input logic dec, input logic [2:0] credit);
        logic [3:0] v;
        v = {2'b00, cnt};
        if (inc && !dec)
            v = v + 4'd1;
        else if (dec && !inc && cnt != 2'd0)
            v = v - 4'd1;
        v = v + {1'b0, credit};
        return (v > 4'd3) ? 2'd3 : v[1:0];
    endfunction

    assign w_inc_c = i_restock && (i_restock_coin == CIRCLE);
    assign w_inc_t = i_restock && (i_restock_coin == TRIANGLE);
    assign w_inc_p = i_restock && (i_restock_coin == PENTAGON);
    assign w_dec_c = i_dispense && (i_dispense_coin == CIRCLE);
    assign w_dec_t = i_dispense && (i_dispense_coin == TRIANGLE);
    assign w_dec_p = i_dispense && (i_dispense_coin == PENTAGON);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_circles   <= 2'd0;
            r_triangles <= 2'd0;
            r_pentagons <= 2'd0;
        end else begin
            r_circles   <= next_count(r_circles,   w_inc_c, w_dec_c, i_credit_c);
            r_triangles <= next_count(r_triangles, w_inc_t, w_dec_t, i_credit_t);
            r_pentagons <= next_count(r_pentagons, w_inc_p, w_dec_p, i_credit_p);
        end
    end

    assign o_circles   = r_circles;
    assign o_triangles = r_triangles;
    assign o_pentagons = r_pentagons;

endmodule

// File: rtl/coin_vend_controller.sv
// Vending controller: collects payment, consults the ChangeMachine, dispenses up to two change coins.
// Optional CHANGE_ESCROW_EN: inserted coins are credited to the change inventory on entry to DONE.
module coin_vend_controller
    import change_pkg::*;
(
    input  logic       CLOCK_100,
    input  logic       reset,
    input  logic [3:0] CostIn,
    input  logic       SetCost,
    input  logic       InsertCoin,
    input  logic       Restock,
    input  logic [2:0] CoinType,
    input  logic       Vend,
    input  logic       Cancel,
    output logic [3:0] Cost,
    output logic [3:0] Paid,
    output logic [1:0] Pentagons,
    output logic [1:0] Triangles,
    output logic [1:0] Circles,
    input  logic [2:0] FirstCoin,
    input  logic [2:0] SecondCoin,
    input  logic       ExactAmount,
    input  logic       NotEnoughChange,
    input  logic       CoughUpMore,
    output logic       DispenseValid,
    output logic [2:0] DispenseCoin,
    input  logic       DispenseReady,
    output logic       Done,
    output logic       Refund,
    output logic       CoinReject,
    output logic       ShortPay,
    output logic       NoChange,
    output logic [3:0] RefundAmount,
    output logic [2:0] State
);

    state_t     r_state, w_state;
    logic [3:0] r_cost, w_cost, r_paid, w_paid, r_refund_amt, w_refund_amt;
    logic [2:0] r_first, w_first, r_second, w_second;
    logic       r_exact, w_exact, r_nec, w_nec, r_cum, w_cum;
    logic       r_sel_second, w_sel_second;
    logic       r_refund, w_refund, r_reject, w_reject, r_shortpay, w_shortpay;
    logic       r_nochange, w_nochange;
    logic [4:0] w_sum;
    logic [2:0] w_disp_coin;
    logic       w_fire, w_enter_done;
    logic [2:0] w_credit_c, w_credit_t, w_credit_p;

    assign w_sum        = {1'b0, r_paid} + {1'b0, coin_value(CoinType)};
    assign w_disp_coin  = r_sel_second ? r_second : r_first;
    assign w_fire       = DispenseValid && DispenseReady;
    assign w_enter_done = (w_state == DONE) && (r_state != DONE);

    always_comb begin
        w_state      = r_state;
        w_cost       = r_cost;
        w_paid       = r_paid;
        w_first      = r_first;
        w_second     = r_second;
        w_exact      = r_exact;
        w_nec        = r_nec;
        w_cum        = r_cum;
        w_sel_second = r_sel_second;
        w_refund     = 1'b0;
        w_refund_amt = 4'd0;
        w_reject     = 1'b0;
        w_shortpay   = 1'b0;
        w_nochange   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (SetCost && CostIn != 4'd0) begin
                    w_cost  = CostIn;
                    w_paid  = 4'd0;
                    w_state = COLLECT;
                end
            end
            COLLECT: begin
                if (Cancel) begin
                    w_refund     = 1'b1;
                    w_refund_amt = r_paid;
                    w_paid       = 4'd0;
                    w_cost       = 4'd0;
                    w_state      = IDLE;
                end else if (Vend) begin
                    w_state = EVAL;
                end else if (InsertCoin) begin
                    if (coin_valid(CoinType) && w_sum <= 5'(MAX_PAID))
                        w_paid = w_sum[3:0];
                    else
                        w_reject = 1'b1;
                end
            end
            EVAL: begin
                w_first      = FirstCoin;
                w_second     = SecondCoin;
                w_exact      = ExactAmount;
                w_nec        = NotEnoughChange;
                w_cum        = CoughUpMore;
                w_sel_second = 1'b0;
                if (CoughUpMore) begin
                    w_state    = COLLECT;
                    w_shortpay = 1'b1;
                end else if (NotEnoughChange) begin
                    w_state    = COLLECT;
                    w_nochange = 1'b1;
                end else if (ExactAmount) begin
                    w_state = DONE;
                end else begin
                    w_state = DISPENSE;
                end
            end
            DISPENSE: begin
                if (DispenseReady) begin
                    if (!r_sel_second && r_second != NONE)
                        w_sel_second = 1'b1;
                    else
                        w_state = DONE;
                end
            end
            DONE: begin
                w_cost  = 4'd0;
                w_paid  = 4'd0;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_100) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cost       <= 4'd0;
            r_paid       <= 4'd0;
            r_first      <= 3'd0;
            r_second     <= 3'd0;
            r_exact      <= 1'b0;
            r_nec        <= 1'b0;
            r_cum        <= 1'b0;
            r_sel_second <= 1'b0;
            r_refund     <= 1'b0;
            r_refund_amt <= 4'd0;
            r_reject     <= 1'b0;
            r_shortpay   <= 1'b0;
            r_nochange   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cost       <= w_cost;
            r_paid       <= w_paid;
            r_first      <= w_first;
            r_second     <= w_second;
            r_exact      <= w_exact;
            r_nec        <= w_nec;
            r_cum        <= w_cum;
            r_sel_second <= w_sel_second;
            r_refund     <= w_refund;
            r_refund_amt <= w_refund_amt;
            r_reject     <= w_reject;
            r_shortpay   <= w_shortpay;
            r_nochange   <= w_nochange;
        end
    end

`ifdef CHANGE_ESCROW_EN
    logic [2:0] r_tally_c, r_tally_t, r_tally_p;
    logic       w_accept;

    assign w_accept = (r_state == COLLECT) && InsertCoin && !Cancel && !Vend &&
                      coin_valid(CoinType) && (w_sum <= 5'(MAX_PAID));

    always_ff @(posedge CLOCK_100) begin
        if (reset || r_state == IDLE) begin
            r_tally_c <= 3'd0;
            r_tally_t <= 3'd0;
            r_tally_p <= 3'd0;
        end else if (w_accept) begin
            case (CoinType)
                CIRCLE:   if (r_tally_c != 3'd7) r_tally_c <= r_tally_c + 3'd1;
                TRIANGLE: if (r_tally_t != 3'd7) r_tally_t <= r_tally_t + 3'd1;
                PENTAGON: if (r_tally_p != 3'd7) r_tally_p <= r_tally_p + 3'd1;
                default: ;
            endcase
        end
    end

    assign w_credit_c = w_enter_done ? r_tally_c : 3'd0;
    assign w_credit_t = w_enter_done ? r_tally_t : 3'd0;
    assign w_credit_p = w_enter_done ? r_tally_p : 3'd0;
`else
    assign w_credit_c = 3'd0;
    assign w_credit_t = 3'd0;
    assign w_credit_p = 3'd0;
`endif

    coin_inventory u_inventory (
        .i_clk           (CLOCK_100),
        .i_rst           (reset),
        .i_restock       (Restock),
        .i_restock_coin  (CoinType),
        .i_dispense      (w_fire),
        .i_dispense_coin (w_disp_coin),
        .i_credit_c      (w_credit_c),
        .i_credit_t      (w_credit_t),
        .i_credit_p      (w_credit_p),
        .o_circles       (Circles),
        .o_triangles     (Triangles),
        .o_pentagons     (Pentagons)
    );

    // Dispense only follows an evaluation that asked for change.
    assign DispenseValid = (r_state == DISPENSE) && !r_exact && !r_nec && !r_cum;
    assign DispenseCoin  = DispenseValid ? w_disp_coin : 3'd0;
    assign Done          = (r_state == DONE);
    assign Cost          = r_cost;
    assign Paid          = r_paid;
    assign Refund        = r_refund;
    assign RefundAmount  = r_refund_amt;
    assign CoinReject    = r_reject;
    assign ShortPay      = r_shortpay;
    assign NoChange      = r_nochange;
    assign State         = r_state;

endmodule

// File: tb/tb_coin_vend_controller.sv
// Bench for coin_vend_controller: behavioural ChangeMachine, transaction-level reference model,
// directed scenarios and a randomized run. Honours CHANGE_ESCROW_EN like the design.
module tb_coin_vend_controller;

`ifdef CHANGE_ESCROW_EN
    localparam int ESCROW = 1;
`else
    localparam int ESCROW = 0;
`endif

    logic       CLOCK_100 = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] CostIn = '0;
    logic       SetCost = 0, InsertCoin = 0, Restock = 0, Vend = 0, Cancel = 0;
    logic [2:0] CoinType = '0;
    logic [3:0] Cost, Paid, RefundAmount;
    logic [1:0] Pentagons, Triangles, Circles;
    logic [2:0] FirstCoin, SecondCoin, DispenseCoin, State;
    logic       ExactAmount, NotEnoughChange, CoughUpMore;
    logic       DispenseValid, DispenseReady = 0;
    logic       Done, Refund, CoinReject, ShortPay, NoChange;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK_100 = ~CLOCK_100;

    coin_vend_controller dut (
        .CLOCK_100(CLOCK_100), .reset(reset), .CostIn(CostIn), .SetCost(SetCost),
        .InsertCoin(InsertCoin), .Restock(Restock), .CoinType(CoinType), .Vend(Vend),
        .Cancel(Cancel), .Cost(Cost), .Paid(Paid), .Pentagons(Pentagons),
        .Triangles(Triangles), .Circles(Circles), .FirstCoin(FirstCoin),
        .SecondCoin(SecondCoin), .ExactAmount(ExactAmount),
        .NotEnoughChange(NotEnoughChange), .CoughUpMore(CoughUpMore),
        .DispenseValid(DispenseValid), .DispenseCoin(DispenseCoin),
        .DispenseReady(DispenseReady), .Done(Done), .Refund(Refund),
        .CoinReject(CoinReject), .ShortPay(ShortPay), .NoChange(NoChange),
        .RefundAmount(RefundAmount), .State(State)
    );

    // ChangeMachine: status and up to two change coins drawn from the current inventory.
    function automatic logic [8:0] cm_eval(input int cost, input int paid,
                                           input int c, input int t, input int p);
        int   cnt [8];
        int   vals [3];
        int   ch, f, s;
        logic ex, nec, cum, found;
        vals = '{5, 3, 1};
        cnt = '{default: 0};
        cnt[1] = c; cnt[3] = t; cnt[5] = p;
        f = 0; s = 0; ex = 0; nec = 0; cum = 0; found = 0; ch = 0;
        if (paid < cost) cum = 1;
        else if (paid == cost) ex = 1;
        else begin
            ch = paid - cost;
            for (int i = 0; i < 3; i++)
                if (!found && vals[i] == ch && cnt[vals[i]] >= 1) begin f = vals[i]; found = 1; end
            for (int i = 0; i < 3; i++)
                for (int j = i; j < 3; j++)
                    if (!found && vals[i] + vals[j] == ch &&
                        ((i == j) ? (cnt[vals[i]] >= 2) : (cnt[vals[i]] >= 1 && cnt[vals[j]] >= 1))) begin
                        f = vals[i]; s = vals[j]; found = 1;
                    end
            if (!found) nec = 1;
        end
        return {3'(f), 3'(s), ex, nec, cum};
    endfunction

    logic [8:0] cm_bus;
    assign cm_bus = cm_eval(int'(Cost), int'(Paid), int'(Circles), int'(Triangles), int'(Pentagons));
    assign FirstCoin       = cm_bus[8:6];
    assign SecondCoin      = cm_bus[5:3];
    assign ExactAmount     = cm_bus[2];
    assign NotEnoughChange = cm_bus[1];
    assign CoughUpMore     = cm_bus[0];

    // Reference model, states numbered as shown on the State LEDs.
    localparam int S_IDLE = 0, S_COLL = 1, S_EVAL = 2, S_DISP = 3, S_DONE = 4;
    int m_state, m_cost, m_paid, m_first, m_second, m_sel, m_refamt;
    int m_refund, m_reject, m_short, m_noch;
    int m_inv [8];
    int m_tally [8];

    function automatic bit is_coin(input int code);
        return code == 1 || code == 3 || code == 5;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_cost = 0; m_paid = 0; m_first = 0; m_second = 0; m_sel = 0;
        m_refamt = 0; m_refund = 0; m_reject = 0; m_short = 0; m_noch = 0;
        m_inv = '{default: 0};
        m_tally = '{default: 0};
    endtask

    task automatic model_step();
        int inc [8];
        int dec [8];
        int ns, v, code;
        logic [8:0] r;
        if (reset) begin model_reset(); return; end
        inc = '{default: 0};
        dec = '{default: 0};
        m_refund = 0; m_refamt = 0; m_reject = 0; m_short = 0; m_noch = 0;
        ns = m_state;
        code = int'(CoinType);
        if (Restock && is_coin(code)) inc[code] = 1;
        if (m_state == S_DISP && DispenseReady) dec[m_sel ? m_second : m_first] = 1;
        case (m_state)
            S_IDLE: begin
                m_tally = '{default: 0};
                if (SetCost && CostIn != 0) begin m_cost = int'(CostIn); m_paid = 0; ns = S_COLL; end
            end
            S_COLL: begin
                if (Cancel) begin
                    m_refund = 1; m_refamt = m_paid; m_paid = 0; m_cost = 0; ns = S_IDLE;
                end else if (Vend) ns = S_EVAL;
                else if (InsertCoin) begin
                    if (is_coin(code) && m_paid + code <= 15) begin
                        m_paid += code;
                        if (m_tally[code] < 7) m_tally[code]++;
                    end else m_reject = 1;
                end
            end
            S_EVAL: begin
                r = cm_eval(m_cost, m_paid, m_inv[1], m_inv[3], m_inv[5]);
                m_first = int'(r[8:6]); m_second = int'(r[5:3]); m_sel = 0;
                if (r[0]) begin ns = S_COLL; m_short = 1; end
                else if (r[1]) begin ns = S_COLL; m_noch = 1; end
                else if (r[2]) ns = S_DONE;
                else ns = S_DISP;
            end
            S_DISP: if (DispenseReady) begin
                if (m_sel == 0 && m_second != 0) m_sel = 1;
                else ns = S_DONE;
            end
            default: begin m_cost = 0; m_paid = 0; ns = S_IDLE; end
        endcase
        for (int k = 1; k <= 5; k += 2) begin
            v = m_inv[k];
            if (inc[k] == 1 && dec[k] == 0) v++;
            else if (dec[k] == 1 && inc[k] == 0 && v > 0) v--;
            if (ESCROW == 1 && ns == S_DONE && m_state != S_DONE) v += m_tally[k];
            m_inv[k] = (v > 3) ? 3 : v;
        end
        m_state = ns;
    endtask

    function automatic logic [29:0] act_vec();
        return {State, Cost, Paid, Pentagons, Triangles, Circles, DispenseValid, DispenseCoin,
                Done, Refund, RefundAmount, CoinReject, ShortPay, NoChange};
    endfunction

    function automatic logic [29:0] exp_vec();
        logic dv;
        dv = (m_state == S_DISP);
        return {3'(m_state), 4'(m_cost), 4'(m_paid), 2'(m_inv[5]), 2'(m_inv[3]), 2'(m_inv[1]),
                dv, dv ? 3'(m_sel != 0 ? m_second : m_first) : 3'd0, 1'(m_state == S_DONE),
                1'(m_refund), 4'(m_refamt), 1'(m_reject), 1'(m_short), 1'(m_noch)};
    endfunction

    task automatic tick();
        model_step();
        @(posedge CLOCK_100);
        #1;
        SetCost = 0; InsertCoin = 0; Restock = 0; Vend = 0; Cancel = 0; reset = 0;
    endtask

    task automatic do_reset();                begin reset = 1; tick(); end endtask
    task automatic do_restock(input int c);   begin Restock = 1; CoinType = 3'(c); tick(); end endtask
    task automatic do_setcost(input int c);   begin SetCost = 1; CostIn = 4'(c); tick(); end endtask
    task automatic do_insert(input int c);    begin InsertCoin = 1; CoinType = 3'(c); tick(); end endtask
    task automatic do_vend();                 begin Vend = 1; tick(); end endtask
    task automatic do_cancel();               begin Cancel = 1; tick(); end endtask

    task automatic test_reset();
        DispenseReady = 0;
        do_reset();
        checks++; if (State !== 3'd0) begin errors++; $display("FAIL reset_state act=%0d exp=0", State); end
        checks++; if ({Cost, Paid, RefundAmount} !== 12'd0) begin errors++; $display("FAIL reset_operands act=%h exp=000", {Cost, Paid, RefundAmount}); end
        checks++; if ({Pentagons, Triangles, Circles} !== 6'd0) begin errors++; $display("FAIL reset_inventory act=%h exp=0", {Pentagons, Triangles, Circles}); end
        checks++; if ({DispenseValid, DispenseCoin, Done, Refund, CoinReject, ShortPay, NoChange} !== 9'd0) begin errors++; $display("FAIL reset_outputs act=%h exp=0", {DispenseValid, DispenseCoin, Done, Refund, CoinReject, ShortPay, NoChange}); end
    endtask

    task automatic test_vend_dispense();
        DispenseReady = 0;
        do_reset();
        do_restock(3); do_restock(3); do_restock(1); do_restock(1);
        checks++; if ({Triangles, Circles} !== 4'b1010) begin errors++; $display("FAIL restock_counts act=%b exp=1010", {Triangles, Circles}); end
        do_insert(5);
        checks++; if (CoinReject !== 1'b0 || Paid !== 4'd0) begin errors++; $display("FAIL idle_insert act=%0d/%0d exp=0/0", CoinReject, Paid); end
        do_setcost(7);
        checks++; if (State !== 3'd1 || Cost !== 4'd7) begin errors++; $display("FAIL setcost act=%0d/%0d exp=1/7", State, Cost); end
        do_setcost(3);
        checks++; if (Cost !== 4'd7) begin errors++; $display("FAIL setcost_ignored act=%0d exp=7", Cost); end
        do_insert(5); do_insert(5);
        checks++; if (Paid !== 4'd10) begin errors++; $display("FAIL paid_sum act=%0d exp=10", Paid); end
        do_vend();
        checks++; if (State !== 3'd2) begin errors++; $display("FAIL vend_eval act=%0d exp=2", State); end
        tick();
        checks++; if (State !== 3'd3 || DispenseValid !== 1'b1 || DispenseCoin !== 3'd3) begin errors++; $display("FAIL dispense_coin act=%0d/%0d/%0d exp=3/1/3", State, DispenseValid, DispenseCoin); end
        DispenseReady = 1;
        tick();
        DispenseReady = 0;
        checks++; if (Triangles !== 2'd1 || State !== 3'd4 || Done !== 1'b1) begin errors++; $display("FAIL dispense_done act=%0d/%0d/%0d exp=1/4/1", Triangles, State, Done); end
        tick();
        checks++; if (State !== 3'd0 || Cost !== 4'd0 || Paid !== 4'd0 || Done !== 1'b0) begin errors++; $display("FAIL done_clear act=%0d/%0d/%0d/%0d exp=0/0/0/0", State, Cost, Paid, Done); end
        checks++; if (act_vec() !== exp_vec()) begin errors++; $display("FAIL vend_model act=%h exp=%h", act_vec(), exp_vec()); end
    endtask

    task automatic test_shortpay();
        do_reset();
        do_setcost(7); do_insert(5); do_vend(); tick();
        checks++; if (ShortPay !== 1'b1 || State !== 3'd1 || Paid !== 4'd5 || DispenseValid !== 1'b0) begin errors++; $display("FAIL shortpay act=%0d/%0d/%0d/%0d exp=1/1/5/0", ShortPay, State, Paid, DispenseValid); end
        tick();
        checks++; if (ShortPay !== 1'b0) begin errors++; $display("FAIL shortpay_pulse act=%0d exp=0", ShortPay); end
    endtask

    task automatic test_nochange();
        do_reset();
        do_setcost(4); do_insert(5); do_vend(); tick();
        checks++; if (NoChange !== 1'b1 || State !== 3'd1 || ShortPay !== 1'b0) begin errors++; $display("FAIL nochange act=%0d/%0d/%0d exp=1/1/0", NoChange, State, ShortPay); end
    endtask

    task automatic test_reject_cancel();
        do_reset();
        do_setcost(14); do_insert(5); do_insert(5); do_insert(3);
        checks++; if (Paid !== 4'd13) begin errors++; $display("FAIL paid13 act=%0d exp=13", Paid); end
        do_insert(5);
        checks++; if (CoinReject !== 1'b1 || Paid !== 4'd13) begin errors++; $display("FAIL reject_overflow act=%0d/%0d exp=1/13", CoinReject, Paid); end
        do_insert(2);
        checks++; if (CoinReject !== 1'b1 || Paid !== 4'd13) begin errors++; $display("FAIL reject_invalid act=%0d/%0d exp=1/13", CoinReject, Paid); end
        do_cancel();
        checks++; if (Refund !== 1'b1 || RefundAmount !== 4'd13 || State !== 3'd0) begin errors++; $display("FAIL cancel_refund act=%0d/%0d/%0d exp=1/13/0", Refund, RefundAmount, State); end
        checks++; if (Paid !== 4'd0 || Cost !== 4'd0) begin errors++; $display("FAIL cancel_clear act=%0d/%0d exp=0/0", Paid, Cost); end
        tick();
        checks++; if (Refund !== 1'b0 || RefundAmount !== 4'd0) begin errors++; $display("FAIL refund_pulse act=%0d/%0d exp=0/0", Refund, RefundAmount); end
    endtask

    task automatic test_stall_reset();
        DispenseReady = 0;
        do_reset();
        do_restock(5); do_restock(3);
        do_setcost(2); do_insert(5); do_insert(5); do_vend(); tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (DispenseValid !== 1'b1 || DispenseCoin !== 3'd5) begin errors++; $display("FAIL stall_hold%0d act=%0d/%0d exp=1/5", i, DispenseValid, DispenseCoin); end
        end
        DispenseReady = 1;
        tick();
        DispenseReady = 0;
        checks++; if (DispenseValid !== 1'b1 || DispenseCoin !== 3'd3 || Pentagons !== 2'd0) begin errors++; $display("FAIL second_coin act=%0d/%0d/%0d exp=1/3/0", DispenseValid, DispenseCoin, Pentagons); end
        reset = 1; DispenseReady = 1;
        tick();
        DispenseReady = 0;
        checks++; if (act_vec() !== 30'd0) begin errors++; $display("FAIL reset_mid_dispense act=%h exp=0", act_vec()); end
    endtask

    task automatic test_escrow();
        do_reset();
        do_setcost(5); do_insert(5); do_vend(); tick();
        checks++; if (State !== 3'd4 || Done !== 1'b1) begin errors++; $display("FAIL exact_done act=%0d/%0d exp=4/1", State, Done); end
        checks++; if (Pentagons !== 2'(ESCROW)) begin errors++; $display("FAIL escrow_credit act=%0d exp=%0d", Pentagons, ESCROW); end
        tick();
        checks++; if (State !== 3'd0 || Pentagons !== 2'(ESCROW)) begin errors++; $display("FAIL escrow_idle act=%0d/%0d exp=0/%0d", State, Pentagons, ESCROW); end
    endtask

    task automatic test_random();
        int codes [3];
        codes = '{1, 3, 5};
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            SetCost    = ($urandom_range(0, 7) == 0);
            CostIn     = 4'($urandom_range(0, 15));
            InsertCoin = ($urandom_range(0, 2) == 0);
            Restock    = ($urandom_range(0, 5) == 0);
            CoinType   = ($urandom_range(0, 3) != 0) ? 3'(codes[$urandom_range(0, 2)]) : 3'($urandom_range(0, 7));
            Vend       = ($urandom_range(0, 7) == 0);
            Cancel     = ($urandom_range(0, 15) == 0);
            DispenseReady = $urandom_range(0, 1) == 1;
            tick();
            checks++; if (act_vec() !== exp_vec()) begin errors++; $display("FAIL random_cycle%0d act=%h exp=%h", n, act_vec(), exp_vec()); end
        end
        DispenseReady = 0;
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_vend_dispense();
        test_shortpay();
        test_nochange();
        test_reject_cancel();
        test_stall_reset();
        test_escrow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_vend_controller.md
COIN_VEND_CONTROLLER -- requirements
Module: coin_vend_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, ports as below.
REQ-002 CLOCK_100  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 CostIn  in  4  price, loaded by SetCost.
REQ-005 SetCost  in  1  one-cycle load-price strobe.
REQ-006 InsertCoin  in  1  one-cycle coin-inserted strobe.
REQ-007 Restock  in  1  one-cycle add-one-coin-to-inventory strobe.
REQ-008 CoinType  in  3  coin code qualifying InsertCoin and Restock: 1 circle, 3 triangle, 5 pentagon; any other code is invalid.
REQ-009 Vend  in  1  one-cycle request to commit the purchase.
REQ-010 Cancel  in  1  one-cycle request to abort the purchase.
REQ-011 Cost, Paid  out  4 each  registered operands to the ChangeMachine.
REQ-012 Pentagons, Triangles, Circles  out  2 each  registered inventory counts to the ChangeMachine.
REQ-013 FirstCoin, SecondCoin  in  3 each  change coins from the ChangeMachine; 0 means no coin.
REQ-014 ExactAmount, NotEnoughChange, CoughUpMore  in  1 each  status flags from the ChangeMachine.
REQ-015 DispenseValid  out  1 / DispenseCoin  out  3 / DispenseReady  in  1  coin-output handshake.
REQ-016 Done, Refund, CoinReject, ShortPay, NoChange  out  1 each  one-cycle pulses.
REQ-017 RefundAmount  out  4  value returned; valid only while Refund is high.
REQ-018 State  out  3  current FSM state, for LED display.

Function
REQ-019 SHALL implement exactly these FSM states: IDLE, COLLECT, EVAL, DISPENSE, DONE.
REQ-020 SetCost with CostIn≠0, in IDLE: SHALL load Cost, clear Paid, and move to COLLECT.
REQ-021 SetCost in any other state, or with CostIn=0: SHALL be ignored.
REQ-022 InsertCoin with a valid code, in COLLECT: Paid SHALL become Paid+value on the next edge, provided the sum is ≤15.
REQ-023 InsertCoin with a sum >15, or with an invalid code, in COLLECT: Paid SHALL stay unchanged and CoinReject SHALL pulse.
REQ-024 InsertCoin outside COLLECT: SHALL be ignored, with no pulse.
REQ-025 Cancel in COLLECT: SHALL move to IDLE, pulse Refund with RefundAmount=Paid, then clear Paid and Cost.
REQ-026 Cancel in any other state: SHALL be ignored.
REQ-027 Vend in COLLECT: SHALL move to EVAL; if Cancel is also asserted in the same cycle, Cancel wins.
REQ-028 EVAL SHALL last exactly one cycle; at its closing edge, FirstCoin, SecondCoin and the three flags SHALL be latched.
REQ-029 EVAL branch order at that edge: CoughUpMore → COLLECT + ShortPay; else NotEnoughChange → COLLECT + NoChange; else ExactAmount → DONE; else → DISPENSE.
REQ-030 DISPENSE: DispenseValid high, DispenseCoin = the latched FirstCoin.
REQ-031 On the first Valid&&Ready: decrement that coin's inventory; then present SecondCoin if it is nonzero, else go to DONE.
REQ-032 On the second Valid&&Ready: decrement that coin's inventory and go to DONE.
REQ-033 While Ready is low in DISPENSE: DispenseValid and DispenseCoin SHALL be held stable.
REQ-034 DONE: SHALL last one cycle, pulse Done, clear Cost and Paid, and return to IDLE.
REQ-035 Restock with a valid code in any state: increment that coin's count, saturating at 3.
REQ-036 Restock in the same cycle as a dispense decrement of the same type: net change SHALL be 0.
REQ-037 Inventory SHALL never underflow; a decrement at 0 holds 0.

Reset
REQ-038 reset SHALL dominate all other inputs, including mid-DISPENSE, forcing State=IDLE.
REQ-039 On reset: Cost=0, Paid=0, all inventory counts=0, latched coins/flags=0.
REQ-040 On reset: all pulses low, DispenseValid=0, DispenseCoin=0, RefundAmount=0.

Configuration
REQ-041 Macro CHANGE_ESCROW_EN defined: on entry to DONE, each inserted coin SHALL be credited to inventory (saturating at 3).
REQ-042 This crediting SHALL apply to the same coin type after any dispense decrement; per-type insert tallies are 3-bit saturating and cleared in IDLE.
REQ-043 Macro CHANGE_ESCROW_EN undefined: inventory SHALL change only by Restock and dispense, and no tallies SHALL exist.

Structure
REQ-044 Package change_pkg SHALL hold the coin_t codes (NONE=0, CIRCLE=1, TRIANGLE=3, PENTAGON=5), the state_t enum, and MAX_PAID=15.
REQ-045 Sub-module coin_inventory SHALL hold three 2-bit saturating up/down counters with restock/dispense ports.

Verification
REQ-046 Reset; Restock 3,3,1,1; SetCost 7; insert 5,5; Vend → EVAL (1 cycle); DispenseCoin=3 with Ready; Triangles 2→1; Done.
REQ-047 Cost 7, Paid 5, Vend → ShortPay pulse, State=COLLECT, Paid=5, no dispense.
REQ-048 Cost 4, empty inventory, Paid 5, Vend → NoChange pulse, State back to COLLECT.
REQ-049 Paid 13, insert pentagon → CoinReject, Paid=13; then Cancel → Refund with RefundAmount=13, State=IDLE.
REQ-050 Two-coin change with Ready low 3 cycles → Valid/Coin stable; reset asserted mid-DISPENSE → all outputs at reset values next cycle.
REQ-051 CHANGE_ESCROW_EN build: Cost 5, insert 5, Vend → ExactAmount → DONE, Pentagons 0→1; non-escrow build: Pentagons stays 0.
